lz_sched: RTL

LZ_SCHED -- requirements
Module: lz_sched

---
 rtl/lz_sched.sv | 111 +++++++++++
 1 files changed

// File: rtl/lz_sched.sv
// lz_sched: two-requester round-robin scheduler feeding bursts to a leading-zero engine
// Ports: CLK, rst_n (async active-low); req0_*/req1_* word streams (valid/ready/mode/data);
//        lz_ivalid/lz_mode/lz_data words to the engine, lz_ovalid/lz_zero result from it;
//        rsp_valid/rsp_id/rsp_zero/rsp_err one-cycle result pulse with owner and timeout flag.
module lz_sched #(
   parameter int WIDTH = 8,
   parameter int WORD  = 4,
   parameter int TMO   = 16
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic             req0_mode,
   input  logic             req1_mode,
   input  logic [WIDTH-1:0] req0_data,
   input  logic [WIDTH-1:0] req1_data,
   output logic             lz_ivalid,
   output logic             lz_mode,
   output logic [WIDTH-1:0] lz_data,
   input  logic             lz_ovalid,
   input  logic [8:0]       lz_zero,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [8:0]       rsp_zero,
   output logic             rsp_err
);
   localparam int CW = $clog2(WORD + 1);
   localparam int TW = $clog2(TMO + 1);
   typedef enum logic [2:0] {IDLE, SEND, DRAIN, WAIT, RESP} state_t;
   state_t           state, state_nx;
   logic             gnt, last_g, pick, mode_r, err_r;
   logic             g_valid, g_mode, busy, acc, fin, tmo_done;
   logic [WIDTH-1:0] g_data;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    tmo;
   logic [8:0]       zero_r;
   always_comb begin
      g_valid    = gnt ? req1_valid : req0_valid;
      g_mode     = gnt ? req1_mode : req0_mode;
      g_data     = gnt ? req1_data : req0_data;
      // last_g resets to 1 so that requester 0 wins the first contested grant
      pick       = (req0_valid && req1_valid) ? !last_g : req1_valid;
      busy       = state == SEND || state == DRAIN;
      acc        = busy && g_valid;
      fin        = acc && cnt == CW'(WORD - 1);
      tmo_done   = tmo == TW'(TMO - 1);
      req0_ready = busy && !gnt;
      req1_ready = busy && gnt;
      lz_ivalid  = state == SEND && g_valid;
      lz_data    = state == SEND ? g_data : '0;
      // the first word carries the mode straight through; later words use the latch
      lz_mode    = (state == SEND && cnt == '0 && g_valid) ? g_mode : ((busy || state == WAIT) && mode_r);
      rsp_valid  = state == RESP;
      rsp_id     = rsp_valid && gnt;
      rsp_zero   = rsp_valid ? zero_r : '0;
      rsp_err    = rsp_valid && err_r;
      state_nx   = state;
      case (state)
         IDLE:    state_nx = (req0_valid || req1_valid) ? SEND : IDLE;
         SEND:    state_nx = lz_ovalid ? (fin ? RESP : DRAIN) : (fin ? WAIT : SEND);
         DRAIN:   state_nx = fin ? RESP : DRAIN;
         WAIT:    state_nx = (lz_ovalid || tmo_done) ? RESP : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt    <= 1'b0;
         last_g <= 1'b1;
         cnt    <= '0;
         tmo    <= '0;
         mode_r <= 1'b0;
         zero_r <= '0;
         err_r  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               cnt    <= '0;
               tmo    <= '0;
               mode_r <= 1'b0;
               if (req0_valid || req1_valid) gnt <= pick;
            end
            SEND: begin
               if (acc) cnt <= cnt + CW'(1);
               if (acc && cnt == '0) mode_r <= g_mode;
               if (lz_ovalid) begin
                  zero_r <= lz_zero;
                  err_r  <= 1'b0;
               end
            end
            DRAIN: if (acc) cnt <= cnt + CW'(1);
            WAIT: begin
               tmo <= tmo + TW'(1);
               if (lz_ovalid) begin
                  zero_r <= lz_zero;
                  err_r  <= 1'b0;
               end else if (tmo_done) begin
                  zero_r <= 9'h1FF;
                  err_r  <= 1'b1;
               end
            end
            default: last_g <= gnt;
         endcase
      end
   end
endmodule
